feed_sched: RTL and testbench

- Sequences the FEED phase of one 4x4 block pass into the systolic array.
- Started by the top controller's feed command. Generates skewed per-row A read enables/indices and per-column B read enables/indices for the local block buffers, plus the PE accumulate enable.
- Returns a feed-done interrupt once the last operand has propagated through the array.
- The top controller owns block/global indexing; this block owns only intra-block timing.

---
 rtl/feed_sched_if.sv | 51 +++++
 rtl/feed_sched.sv | 204 ++++++++++++++++++++
 tb/tb_feed_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/feed_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : feed_sched_if
//  Purpose  : Bundle between the top controller and the FEED-phase sequencer
//             (command/clear/K-depth in, skewed buffer reads and status out).
//  Options  : FEED_STALL_EN adds the 'stall' request line.
//  Revision : 1.0  initial release
// ============================================================================
interface feed_sched_if #(
  parameter int ARR   = 4,
  parameter int IDX_W = 2
);
  // Controller -> sequencer
  logic                 cmd_feed;
  logic                 dp_cnt_rst;
  logic [IDX_W:0]       k_len;
`ifdef FEED_STALL_EN
  logic                 stall;
`endif

  // Sequencer -> buffers / PE array / controller
  logic [ARR-1:0]       a_rd_en;
  logic [ARR*IDX_W-1:0] a_rd_idx;
  logic [ARR-1:0]       b_rd_en;
  logic [ARR*IDX_W-1:0] b_rd_idx;
  logic                 acc_en;
  logic                 feed_done;
  logic                 busy;

`ifdef FEED_STALL_EN
  modport master (
    output cmd_feed, dp_cnt_rst, k_len, stall,
    input  a_rd_en, a_rd_idx, b_rd_en, b_rd_idx, acc_en, feed_done, busy
  );
  modport slave (
    input  cmd_feed, dp_cnt_rst, k_len, stall,
    output a_rd_en, a_rd_idx, b_rd_en, b_rd_idx, acc_en, feed_done, busy
  );
`else
  modport master (
    output cmd_feed, dp_cnt_rst, k_len,
    input  a_rd_en, a_rd_idx, b_rd_en, b_rd_idx, acc_en, feed_done, busy
  );
  modport slave (
    input  cmd_feed, dp_cnt_rst, k_len,
    output a_rd_en, a_rd_idx, b_rd_en, b_rd_idx, acc_en, feed_done, busy
  );
`endif

endinterface : feed_sched_if
`default_nettype wire

// File: rtl/feed_sched.sv
`default_nettype none
// ============================================================================
//  Module   : feed_sched
//  Purpose  : Sequences the FEED phase of one ARRxARR block pass into the
//             systolic array: skewed A-row / B-column buffer reads, PE
//             accumulate enable and a level feed-done interrupt.
//  Options  : FEED_STALL_EN adds a stall input that freezes the sequence.
//  Revision : 1.0  initial release
// ============================================================================
module feed_sched #(
  parameter int ARR   = 4,
  parameter int IDX_W = 2,
  parameter int T_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  feed_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int             K_W         = IDX_W + 1;
  localparam logic [K_W-1:0] C_K_MAX     = K_W'(ARR);
  // Last FEED time is K+ARR-2, last DRAIN time is K+2*ARR-3.
  localparam logic [T_W-1:0] C_FEED_OFS  = T_W'(ARR - 2);
  localparam logic [T_W-1:0] C_DRAIN_OFS = T_W'(2 * ARR - 3);

  // Sequencing state
  state_t         state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic [K_W-1:0] k_q, k_d;

  // Registered outputs
  logic [ARR-1:0]       a_en_q, a_en_d;
  logic [ARR*IDX_W-1:0] a_idx_q, a_idx_d;
  logic [ARR-1:0]       b_en_q, b_en_d;
  logic [ARR*IDX_W-1:0] b_idx_q, b_idx_d;
  logic                 acc_q, acc_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 stall_w;
  logic                 stall_act_w;
  logic [K_W-1:0]       k_clamp_w;
  logic [T_W-1:0]       feed_last_w;
  logic [T_W-1:0]       drain_last_w;
  logic [T_W:0]         a_diff_w;
  logic [T_W:0]         b_diff_w;

`ifdef FEED_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  // A stall only has meaning while operands are moving.
  assign stall_act_w  = stall_w && ((state_q == S_FEED) || (state_q == S_DRAIN));

  // Depths above the array size cannot be fed; treat them as a full block.
  assign k_clamp_w    = (bus.k_len > C_K_MAX) ? C_K_MAX : bus.k_len;

  assign feed_last_w  = T_W'(k_q) + C_FEED_OFS;
  assign drain_last_w = T_W'(k_q) + C_DRAIN_OFS;

  // State, time and latched depth registers; clear on reset or datapath clear.
  always_ff @(posedge clk) begin
    if (reset || bus.dp_cnt_rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: walk IDLE -> FEED -> DRAIN -> DONE on the time counter.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_feed) begin
          k_d     = k_clamp_w;
          t_d     = '0;
          state_d = (bus.k_len == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (!stall_act_w) begin
          t_d = t_q + 1'b1;
          if (t_q == feed_last_w) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!stall_act_w) begin
          t_d = t_q + 1'b1;
          if (t_q == drain_last_w) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // feed_done is a level held until the controller drops its command.
        if (!bus.cmd_feed) begin
          state_d = S_IDLE;
          t_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // A-row skew decode: row i reads K index t-i while i <= t <= i+K-1.
  // Decoded from the next state so the registered outputs line up with
  // the state/time they belong to.
  always_comb begin
    a_en_d   = '0;
    a_idx_d  = '0;
    a_diff_w = '0;
    for (int i = 0; i < ARR; i++) begin
      // Extra MSB flags t < i without an unsigned compare against zero.
      a_diff_w = {1'b0, t_d} - {1'b0, T_W'(i)};
      if ((state_d == S_FEED) && !a_diff_w[T_W] &&
          (a_diff_w[T_W-1:0] < T_W'(k_d))) begin
        a_en_d[i]                 = 1'b1;
        a_idx_d[i*IDX_W +: IDX_W] = a_diff_w[IDX_W-1:0];
      end
    end
    if (stall_act_w) begin
      a_en_d  = '0;
      a_idx_d = a_idx_q;
    end
  end

  // B-column skew decode: same wavefront as the A rows, per column j.
  always_comb begin
    b_en_d   = '0;
    b_idx_d  = '0;
    b_diff_w = '0;
    for (int j = 0; j < ARR; j++) begin
      b_diff_w = {1'b0, t_d} - {1'b0, T_W'(j)};
      if ((state_d == S_FEED) && !b_diff_w[T_W] &&
          (b_diff_w[T_W-1:0] < T_W'(k_d))) begin
        b_en_d[j]                 = 1'b1;
        b_idx_d[j*IDX_W +: IDX_W] = b_diff_w[IDX_W-1:0];
      end
    end
    if (stall_act_w) begin
      b_en_d  = '0;
      b_idx_d = b_idx_q;
    end
  end

  // Status decode: accumulate while operands are in flight, done/busy levels.
  always_comb begin
    acc_d  = ((state_d == S_FEED) || (state_d == S_DRAIN)) && !stall_act_w;
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // Output registers; the clear path forces every output low next cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.dp_cnt_rst) begin
      a_en_q  <= '0;
      a_idx_q <= '0;
      b_en_q  <= '0;
      b_idx_q <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      a_en_q  <= a_en_d;
      a_idx_q <= a_idx_d;
      b_en_q  <= b_en_d;
      b_idx_q <= b_idx_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.a_rd_en   = a_en_q;
  assign bus.a_rd_idx  = a_idx_q;
  assign bus.b_rd_en   = b_en_q;
  assign bus.b_rd_idx  = b_idx_q;
  assign bus.acc_en    = acc_q;
  assign bus.feed_done = done_q;
  assign bus.busy      = busy_q;

endmodule : feed_sched
`default_nettype wire

// File: tb/tb_feed_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_feed_sched
//  Purpose  : Directed self-checking bench for feed_sched (ARR=4, IDX_W=2).
//             Stall scenario is compiled in when FEED_STALL_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_feed_sched;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  feed_sched_if #(.ARR(4), .IDX_W(2)) bus ();

  feed_sched #(.ARR(4), .IDX_W(2), .T_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int n;

  // Hand-computed wavefront for K=4: enables and packed indices per t=0..9.
  logic [3:0] ea4 [10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                           4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic [7:0] ei4 [10] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C,
                           8'hB0, 8'hC0, 8'h00, 8'h00, 8'h00};
  // Same for K=2, t=0..7.
  logic [3:0] ea2 [8]  = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000,
                           4'b0000, 4'b0000, 4'b0000};
  logic [7:0] ei2 [8]  = '{8'h00, 8'h01, 8'h04, 8'h10, 8'h40,
                           8'h00, 8'h00, 8'h00};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs();
    return {5'b0, bus.busy, bus.feed_done, bus.acc_en,
            bus.b_rd_idx, bus.b_rd_en, bus.a_rd_idx, bus.a_rd_en};
  endfunction

  // Expected word: B mirrors A in this square, equal-K configuration.
  function automatic logic [31:0] pk(input logic [3:0] en, input logic [7:0] idx,
                                     input logic acc, input logic done,
                                     input logic busy);
    return {5'b0, busy, done, acc, idx, en, idx, en};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.cmd_feed   = 1'b0;
    bus.dp_cnt_rst = 1'b0;
    bus.k_len      = '0;
`ifdef FEED_STALL_EN
    bus.stall      = 1'b0;
`endif
    step();
    step();
    chk("reset_state", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    step();
    chk("idle_no_cmd", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));

    // Full block K=4, command held high through DONE.
    bus.k_len    = 3'd4;
    bus.cmd_feed = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step();
      chk($sformatf("k4_t%0d", s), obs(), pk(ea4[s], ei4[s], 1'b1, 1'b0, 1'b1));
    end
    step();
    chk("k4_done", obs(), pk(4'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    step();
    chk("k4_done_hold", obs(), pk(4'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    bus.cmd_feed = 1'b0;
    step();
    chk("k4_back_idle", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));

    // Partial K=2; command dropped and k_len changed mid-FEED are ignored.
    bus.k_len    = 3'd2;
    bus.cmd_feed = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step();
      chk($sformatf("k2_t%0d", s), obs(), pk(ea2[s], ei2[s], 1'b1, 1'b0, 1'b1));
      if (s == 1) begin
        bus.cmd_feed = 1'b0;
        bus.k_len    = 3'd3;
      end
    end
    step();
    chk("k2_done", obs(), pk(4'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    step();
    chk("k2_done_exit", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));

    // K=0 goes straight to DONE with no reads and no accumulate.
    bus.k_len    = 3'd0;
    bus.cmd_feed = 1'b1;
    step();
    chk("k0_done", obs(), pk(4'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    bus.cmd_feed = 1'b0;
    step();
    chk("k0_idle", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));

    // K=7 clamps to the array size: same wavefront and latency as K=4.
    bus.k_len    = 3'd7;
    bus.cmd_feed = 1'b1;
    step();
    chk("k7_t0", obs(), pk(4'b0001, 8'h00, 1'b1, 1'b0, 1'b1));
    step();
    step();
    step();
    chk("k7_t3", obs(), pk(4'b1111, 8'h1B, 1'b1, 1'b0, 1'b1));
    step();
    chk("k7_t4", obs(), pk(4'b1110, 8'h6C, 1'b1, 1'b0, 1'b1));
    n = 4;
    while (!bus.feed_done && n < 30) begin
      step();
      n++;
    end
    chk("k7_done_latency", 32'(n), 32'd10);
    bus.cmd_feed = 1'b0;
    step();
    chk("k7_idle", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));

    // Datapath clear at t=3, then a fresh sequence with cmd still high.
    bus.k_len    = 3'd4;
    bus.cmd_feed = 1'b1;
    for (int s = 0; s < 4; s++) step();
    chk("clr_pre_t3", obs(), pk(4'b1111, 8'h1B, 1'b1, 1'b0, 1'b1));
    bus.dp_cnt_rst = 1'b1;
    step();
    chk("clr_outputs_zero", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));
    bus.dp_cnt_rst = 1'b0;
    step();
    chk("clr_restart_t0", obs(), pk(4'b0001, 8'h00, 1'b1, 1'b0, 1'b1));

    // Reset in DRAIN (t=7): outputs clear, no done pulse follows.
    for (int s = 0; s < 7; s++) step();
    chk("rst_pre_drain", obs(), pk(4'h0, 8'h00, 1'b1, 1'b0, 1'b1));
    reset = 1'b1;
    step();
    chk("rst_outputs_zero", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));
    reset        = 1'b0;
    bus.cmd_feed = 1'b0;
    step();
    chk("rst_no_done_1", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));
    step();
    step();
    chk("rst_no_done_3", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));

`ifdef FEED_STALL_EN
    // Three-cycle stall covering the t=2 slot: no enables, indices held,
    // the t=2 pattern then resumes and done moves out by three cycles.
    bus.k_len    = 3'd4;
    bus.cmd_feed = 1'b1;
    step();
    chk("stl_t0", obs(), pk(4'b0001, 8'h00, 1'b1, 1'b0, 1'b1));
    step();
    chk("stl_t1", obs(), pk(4'b0011, 8'h01, 1'b1, 1'b0, 1'b1));
    bus.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("stl_hold%0d", s), obs(), pk(4'h0, 8'h01, 1'b0, 1'b0, 1'b1));
    end
    bus.stall = 1'b0;
    step();
    chk("stl_resume_t2", obs(), pk(4'b0111, 8'h06, 1'b1, 1'b0, 1'b1));
    n = 5;
    while (!bus.feed_done && n < 40) begin
      step();
      n++;
    end
    chk("stl_done_latency", 32'(n), 32'd13);
    bus.cmd_feed = 1'b0;
    step();
    chk("stl_idle", obs(), pk(4'h0, 8'h00, 1'b0, 1'b0, 1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_feed_sched
`default_nettype wire
